hdmi_i2c_write_engine: RTL
==========================

# hdmi_i2c_write_engine

Bit-level I2C master that executes one 3-byte write (device address, register address, data) per request on the HDMI transmitter's configuration bus. It sits directly downstream of the HDMI register-configuration sequencer, which presents a 24-bit word and an enable and waits for a one-cycle end strobe plus an acknowledge-error flag. It generates START/STOP, shifts bytes MSB first, samples the slave ACK slots and enforces bus-free time between transactions.

## Interface
- CLK_ref, 1000000: refclk frequency in Hz.
- I2C_clk, 20000: target SCL frequency in Hz.
- refclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- I2C_DATA  in  24  {device addr + R/W=0, register addr, data}; latched at transaction start.
- enable  in  1  level request; a transaction starts when high while IDLE.
- I2C_SCL  out  1  open-drain: drives 0 or releases (Z); no clock stretching.
- I2C_SDA  inout  1  open-drain: drives 0 or releases (Z); read during ACK slots.
- ACK  out  1  acknowledge error: 1 = at least one NACK in the last transaction.
- END  out  1  one-cycle strobe at transaction completion.
- busy  out  1  high from start cycle until GAP ends.

## Operation
- Quarter-phase divider: QDIV = CLK_ref/(4*I2C_clk), integer truncation (default 12). Every phase lasts exactly QDIV refclk cycles. QDIV < 2 is a configuration error and is rejected by elaboration assertion.
- States: IDLE -> START -> BITS -> STOP -> GAP -> IDLE.
- IDLE: SCL and SDA released. When enable=1, latch I2C_DATA into the shift register, clear ACK, clear the divider, and go to START.
- START: 2 phases. Phase 0: SDA=0, SCL released. Phase 1: SCL=0.
- BITS: 27 slots, each of 4 phases. Slots 0-7 carry byte 2, slot 8 is an ACK slot, slots 9-16 carry byte 1, slot 17 is ACK, slots 18-25 carry byte 0, slot 26 is ACK.
  - Phase 0: SCL=0; SDA is set to the data bit (0 drives, 1 releases). In ACK slots SDA is released.
  - Phases 1-2: SCL released.
  - Last cycle of phase 2 in an ACK slot: ACK <= ACK | SDA_in.
  - Phase 3: SCL=0.
- STOP: 4 phases. Phase 0: SCL=0, SDA=0. Phase 1: SCL released. Phase 2: SDA released, which is the STOP edge. Phase 3: hold. On the last cycle of phase 3, END=1 for one cycle.
- GAP: 4 phases with both lines released; enable is ignored. Then go to IDLE.
- A NACK does not abort the transaction: all 27 slots and STOP always complete.
- enable falling mid-transaction has no effect. I2C_DATA changes after the start latch have no effect.
- Back-to-back: if enable is still high in IDLE after GAP, a new transaction starts with the I2C_DATA present in that cycle. GAP guarantees the upstream sequencer (2-cycle advance after END) has already updated I2C_DATA.

## Timing
- Reset, immediate and asynchronous: state IDLE, SCL and SDA released, END=0, ACK=0, busy=0, divider=0, shift register=0. Reset mid-transaction releases both lines without a STOP.
- Start cycle T (IDLE with enable=1): START phase 0 drives SDA low from T+1; busy=1 from T+1.
- Transaction length: 2+108+4 = 114 phases. END is high at cycle T+114*QDIV, which is 1368 with defaults.
- ACK is valid when END is high and holds until the next start cycle.
- GAP is 4*QDIV cycles (48 with defaults). busy falls and IDLE is re-entered at T+118*QDIV+1. The earliest next start is that cycle.
- END never coincides with a START in the same cycle.

## Test plan
- Defaults; I2C_DATA=0x729803, enable pulsed; slave model ACKs all three slots. Required: decoded bus bytes 0x72, 0x98, 0x03; START and STOP legal; every SCL high and low phase is 2*12 cycles; END a single cycle at T+1368; ACK=0.
- Same stimulus with the slave NACKing the data byte (slot 26). Required: all 27 slots and STOP still emitted; END at T+1368; ACK=1; ACK cleared at the next start.
- enable held high; I2C_DATA changed from 0x720100 to 0x720218 two cycles after END. Required: second transaction starts exactly after the 48-cycle GAP and carries 0x02, 0x18; SDA and SCL idle-high throughout the GAP.
- enable dropped and I2C_DATA changed at T+100. Required: bus carries the original word and END still occurs at T+1368.
- rst asserted at T+500 mid-byte. Required: SCL and SDA released in the same cycle, END and ACK are 0, busy=0; after release a fresh transaction runs correctly.
- CLK_ref=50000000, I2C_clk=100000 (QDIV=125). Required: SCL period 500 cycles and END at T+14250.

Source files
------------

// File: rtl/hdmi_i2c_write_engine.sv
// Bit-level I2C master: one 3-byte write (device addr, register addr, data) per request,
// with START/STOP generation, ACK-slot sampling and a bus-free gap between transactions.
module hdmi_i2c_write_engine #(
  parameter int unsigned CLK_ref = 1000000,
  parameter int unsigned I2C_clk = 20000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic [23:0] I2C_DATA,
  input  logic        enable,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        ACK,
  output logic        END,
  output logic        busy
);

  localparam int unsigned QDIV = CLK_ref / (4 * I2C_clk);
  localparam int unsigned DW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(QDIV - 1);
  localparam logic [4:0]    LAST_SLOT = 5'd26;

  if (QDIV < 2) begin : g_bad_qdiv
    $error("hdmi_i2c_write_engine: CLK_ref/(4*I2C_clk) must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP
  } state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_div,   w_div_nx;
  logic [1:0]    r_phase, w_phase_nx;
  logic [4:0]    r_slot,  w_slot_nx;
  logic [23:0]   r_shift, w_shift_nx;
  logic          r_ack,   w_ack_nx;
  logic          w_phase_last, w_ack_slot;
  logic          w_scl_low, w_sda_low, w_end;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_phase <= '0;
      r_slot  <= '0;
      r_shift <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_phase <= w_phase_nx;
      r_slot  <= w_slot_nx;
      r_shift <= w_shift_nx;
      r_ack   <= w_ack_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_div_nx     = r_div;
    w_phase_nx   = r_phase;
    w_slot_nx    = r_slot;
    w_shift_nx   = r_shift;
    w_ack_nx     = r_ack;
    w_scl_low    = 1'b0;
    w_sda_low    = 1'b0;
    w_end        = 1'b0;
    w_phase_last = (r_div == DIV_LAST);
    w_ack_slot   = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == LAST_SLOT);

    // Phase counter wraps naturally for the 4-phase states; START exits explicitly.
    if (r_state != S_IDLE) begin
      w_div_nx = w_phase_last ? '0 : r_div + 1'b1;
      if (w_phase_last) w_phase_nx = r_phase + 2'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nx = S_START;
          w_shift_nx = I2C_DATA;
          w_ack_nx   = 1'b0;
          w_div_nx   = '0;
          w_phase_nx = '0;
          w_slot_nx  = '0;
        end
      end
      S_START: begin
        w_sda_low = 1'b1;
        w_scl_low = (r_phase == 2'd1);
        if (w_phase_last && r_phase == 2'd1) begin
          w_state_nx = S_BITS;
          w_phase_nx = '0;
        end
      end
      S_BITS: begin
        w_scl_low = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_low = !w_ack_slot && !r_shift[23];
        if (w_ack_slot && r_phase == 2'd2 && w_phase_last)
          w_ack_nx = r_ack | I2C_SDA;
        if (w_phase_last && r_phase == 2'd3) begin
          if (!w_ack_slot) w_shift_nx = {r_shift[22:0], 1'b0};
          if (r_slot == LAST_SLOT) w_state_nx = S_STOP;
          else                     w_slot_nx  = r_slot + 5'd1;
        end
      end
      S_STOP: begin
        w_scl_low = (r_phase == 2'd0);
        w_sda_low = !r_phase[1];
        if (w_phase_last && r_phase == 2'd3) begin
          w_end      = 1'b1;
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (w_phase_last && r_phase == 2'd3) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign I2C_SCL = w_scl_low ? 1'b0 : 1'bz;
  assign I2C_SDA = w_sda_low ? 1'b0 : 1'bz;
  assign ACK     = r_ack;
  assign END     = w_end;
  assign busy    = (r_state != S_IDLE);

endmodule
